dino_pose_ctrl: RTL and testbench



---
 rtl/dino_pkg.sv | 26 ++
 rtl/dino_pose_ctrl_if.sv | 31 +++
 rtl/dino_jump_phys.sv | 67 ++++++
 rtl/dino_pose_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_dino_pose_ctrl.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/dino_pkg.sv
// ============================================================================
// dino_pkg: shared sprite encodings, pose states and geometry defaults
// Rev 1.0
// ============================================================================
`default_nettype none
package dino_pkg;

  localparam logic [1:0] SPR_RUN_A = 2'd0;
  localparam logic [1:0] SPR_RUN_B = 2'd1;
  localparam logic [1:0] SPR_DUCK  = 2'd2;
  localparam logic [1:0] SPR_STAND = 2'd3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    DUCK = 3'd2,
    JUMP = 3'd3,
    DEAD = 3'd4
  } state_e;

  localparam int c_GROUND_ROW = 403;
  localparam int c_STAND_H    = 47;
  localparam int c_DUCK_H     = 29;

endpackage
`default_nettype wire

// File: rtl/dino_pose_ctrl_if.sv
// ============================================================================
// dino_pose_ctrl_if: game-status inputs and sprite-addressing outputs of the dino
// Rev 1.0
// ============================================================================
`default_nettype none
interface dino_pose_ctrl_if;

  logic        frame_tick;
  logic [10:0] vc;
  logic        game_run;
  logic        btn_jump;
  logic        btn_duck;
  logic        collision;
  logic [1:0]  sprite_sel;
  logic [10:0] dino_top;
  logic [5:0]  row_idx;
  logic        row_hit;
  logic        dead;

  modport master (
    output frame_tick, vc, game_run, btn_jump, btn_duck, collision,
    input  sprite_sel, dino_top, row_idx, row_hit, dead
  );

  modport slave (
    input  frame_tick, vc, game_run, btn_jump, btn_duck, collision,
    output sprite_sel, dino_top, row_idx, row_hit, dead
  );

endinterface
`default_nettype wire

// File: rtl/dino_jump_phys.sv
// ============================================================================
// dino_jump_phys: per-frame jump height/velocity integrator with landing detect
// Rev 1.0
// ============================================================================
`default_nettype none
module dino_jump_phys #(
  parameter int JUMP_V = 12,
  parameter int GRAV   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_tick,
  input  logic       i_load,
  input  logic       i_step,
  input  logic       i_clear,
  input  logic       i_fast,
  output logic [7:0] o_h,
  output logic [7:0] o_h_nxt,
  output logic       o_land
);

  logic        [7:0] r_h;
  logic signed [7:0] r_v;
  logic signed [8:0] w_sum;
  logic        [7:0] w_dec;
  logic        [7:0] w_h_nxt;
  logic signed [7:0] w_v_nxt;

  assign w_sum  = $signed({1'b0, r_h}) + $signed({r_v[7], r_v});
  assign w_dec  = i_fast ? 8'(3 * GRAV) : 8'(GRAV);
  // Landing is independent of the step strobe so the caller can use it in its state decode.
  assign o_land = (w_sum <= 9'sd0);

  always_comb begin
    w_h_nxt = r_h;
    w_v_nxt = r_v;
    if (i_clear) begin
      w_h_nxt = 8'd0;
      w_v_nxt = 8'sd0;
    end else if (i_load) begin
      w_v_nxt = 8'(JUMP_V);
    end else if (i_step) begin
      if (o_land) begin
        w_h_nxt = 8'd0;
        w_v_nxt = 8'sd0;
      end else begin
        w_h_nxt = w_sum[7:0];
        w_v_nxt = r_v - $signed(w_dec);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h <= 8'd0;
      r_v <= 8'sd0;
    end else if (i_tick) begin
      r_h <= w_h_nxt;
      r_v <= w_v_nxt;
    end
  end

  assign o_h     = r_h;
  assign o_h_nxt = w_h_nxt;

endmodule
`default_nettype wire

// File: rtl/dino_pose_ctrl.sv
// ============================================================================
// dino_pose_ctrl: per-frame dino pose FSM and sprite row addressing (DINO_FAST_FALL_EN)
// Rev 1.0
// ============================================================================
`default_nettype none
module dino_pose_ctrl
  import dino_pkg::*;
#(
  parameter int GROUND_ROW = c_GROUND_ROW,
  parameter int STAND_H    = c_STAND_H,
  parameter int DUCK_H     = c_DUCK_H,
  parameter int JUMP_V     = 12,
  parameter int GRAV       = 1,
  parameter int ANIM_DIV   = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  dino_pose_ctrl_if.slave  bus
);

  localparam logic [10:0] c_GROUND    = 11'(GROUND_ROW);
  localparam logic [10:0] c_TOP_STAND = 11'(GROUND_ROW - STAND_H);
  localparam logic [10:0] c_TOP_DUCK  = 11'(GROUND_ROW - DUCK_H);
  localparam int          c_ANIM_W    = $clog2(ANIM_DIV + 1);

  state_e                r_state;
  state_e                w_state_nxt;
  logic                  r_hit_latch;
  logic [c_ANIM_W-1:0]   r_anim_cnt;
  logic [c_ANIM_W-1:0]   w_anim_nxt;
  logic                  r_run_phase;
  logic                  w_phase_nxt;
  logic [1:0]            r_sprite_sel;
  logic [1:0]            w_sel_nxt;
  logic [10:0]           r_dino_top;
  logic [10:0]           w_top_nxt;
  logic [5:0]            r_row_idx;
  logic                  r_row_hit;
  logic                  r_dead;
  logic                  w_load;
  logic                  w_step;
  logic                  w_clear;
  logic                  w_fast;
  logic                  w_land;
  logic [7:0]            w_h;
  logic [7:0]            w_h_nxt;
  logic [7:0]            w_h_eff;

`ifdef DINO_FAST_FALL_EN
  assign w_fast = bus.btn_duck;
`else
  assign w_fast = 1'b0;
`endif

  assign w_clear = (w_state_nxt == IDLE);

  dino_jump_phys #(
    .JUMP_V (JUMP_V),
    .GRAV   (GRAV)
  ) u_phys (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_tick  (bus.frame_tick),
    .i_load  (w_load),
    .i_step  (w_step),
    .i_clear (w_clear),
    .i_fast  (w_fast),
    .o_h     (w_h),
    .o_h_nxt (w_h_nxt),
    .o_land  (w_land)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    if (!bus.game_run) begin
      w_state_nxt = IDLE;
    end else if (r_hit_latch || bus.collision) begin
      w_state_nxt = DEAD;
    end else begin
      case (r_state)
        IDLE: w_state_nxt = RUN;
        RUN, DUCK: begin
          if (bus.btn_jump) begin
            w_state_nxt = JUMP;
            w_load      = 1'b1;
          end else if (r_state == RUN && bus.btn_duck) begin
            w_state_nxt = DUCK;
          end else if (r_state == DUCK && !bus.btn_duck) begin
            w_state_nxt = RUN;
          end
        end
        JUMP: begin
          w_step = 1'b1;
          if (w_land) w_state_nxt = RUN;
        end
        DEAD:    w_state_nxt = DEAD;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_anim_nxt  = r_anim_cnt;
    w_phase_nxt = r_run_phase;
    if (w_state_nxt == IDLE || r_state == IDLE) begin
      w_anim_nxt  = '0;
      w_phase_nxt = 1'b0;
    end else if (r_state == RUN) begin
      if (r_anim_cnt == c_ANIM_W'(ANIM_DIV - 1)) begin
        w_anim_nxt  = '0;
        w_phase_nxt = ~r_run_phase;
      end else begin
        w_anim_nxt = r_anim_cnt + 1'b1;
      end
    end
  end

  // Pose outputs track the state being entered so they change in the same tick as the state.
  always_comb begin
    w_sel_nxt = SPR_STAND;
    w_top_nxt = c_TOP_STAND;
    case (w_state_nxt)
      RUN:     w_sel_nxt = w_phase_nxt ? SPR_RUN_B : SPR_RUN_A;
      DUCK: begin
        w_sel_nxt = SPR_DUCK;
        w_top_nxt = c_TOP_DUCK;
      end
      JUMP:    w_top_nxt = c_TOP_STAND - {3'b000, w_h_nxt};
      DEAD:    w_top_nxt = r_dino_top;
      default: w_top_nxt = c_TOP_STAND;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_anim_cnt   <= '0;
      r_run_phase  <= 1'b0;
      r_sprite_sel <= SPR_STAND;
      r_dino_top   <= c_TOP_STAND;
      r_dead       <= 1'b0;
    end else if (bus.frame_tick) begin
      r_state      <= w_state_nxt;
      r_anim_cnt   <= w_anim_nxt;
      r_run_phase  <= w_phase_nxt;
      r_sprite_sel <= w_sel_nxt;
      r_dino_top   <= w_top_nxt;
      r_dead       <= (w_state_nxt == DEAD);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_latch <= 1'b0;
    end else if (bus.frame_tick && w_state_nxt == IDLE) begin
      r_hit_latch <= 1'b0;
    end else if (bus.collision && (r_state inside {RUN, DUCK, JUMP})) begin
      r_hit_latch <= 1'b1;
    end
  end

  assign w_h_eff = (r_state == JUMP) ? w_h : 8'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_idx <= 6'd0;
      r_row_hit <= 1'b0;
    end else begin
      r_row_idx <= 6'(bus.vc - r_dino_top);
      r_row_hit <= (bus.vc >= r_dino_top) && (bus.vc < (c_GROUND - {3'b000, w_h_eff}));
    end
  end

  assign bus.sprite_sel = r_sprite_sel;
  assign bus.dino_top   = r_dino_top;
  assign bus.row_idx    = r_row_idx;
  assign bus.row_hit    = r_row_hit;
  assign bus.dead       = r_dead;

endmodule
`default_nettype wire

// File: tb/tb_dino_pose_ctrl.sv
// ============================================================================
// tb_dino_pose_ctrl: directed vector bench for dino_pose_ctrl (DINO_FAST_FALL_EN aware)
// Rev 1.0
// ============================================================================
`default_nettype none
module tb_dino_pose_ctrl;

  typedef struct {
    int          ticks;
    logic        gr;
    logic        jmp;
    logic        dck;
    logic [10:0] vc;
    logic [1:0]  sel;
    logic [10:0] top;
    logic        dead;
    logic [5:0]  idx;
    logic        hit;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  vec_t vt[12];

  dino_pose_ctrl_if u_if ();

  dino_pose_ctrl u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      u_if.frame_tick = 1'b1;
      @(negedge clk);
      u_if.frame_tick = 1'b0;
    end
  endtask

  task automatic chk_pose(input string nm, input int sel, input int top, input int dead);
    chk({nm, ".sel"},  int'(u_if.sprite_sel), sel);
    chk({nm, ".top"},  int'(u_if.dino_top),   top);
    chk({nm, ".dead"}, int'(u_if.dead),       dead);
  endtask

  initial begin
    int  exp_land;
    int  n_land;
    logic landed;

    n_checks = 0;
    n_errors = 0;
    //        ticks gr    jmp   dck   vc       sel   top      dead  idx    hit
    vt[0]  = '{1,  1'b1, 1'b0, 1'b0, 11'd380, 2'd0, 11'd356, 1'b0, 6'd24, 1'b1};
    vt[1]  = '{5,  1'b1, 1'b0, 1'b0, 11'd355, 2'd0, 11'd356, 1'b0, 6'd63, 1'b0};
    vt[2]  = '{1,  1'b1, 1'b0, 1'b0, 11'd402, 2'd1, 11'd356, 1'b0, 6'd46, 1'b1};
    vt[3]  = '{1,  1'b1, 1'b0, 1'b1, 11'd374, 2'd2, 11'd374, 1'b0, 6'd0,  1'b1};
    vt[4]  = '{3,  1'b1, 1'b0, 1'b1, 11'd403, 2'd2, 11'd374, 1'b0, 6'd29, 1'b0};
    vt[5]  = '{1,  1'b1, 1'b0, 1'b0, 11'd356, 2'd1, 11'd356, 1'b0, 6'd0,  1'b1};
    vt[6]  = '{1,  1'b1, 1'b1, 1'b0, 11'd402, 2'd3, 11'd356, 1'b0, 6'd46, 1'b1};
    vt[7]  = '{1,  1'b1, 1'b0, 1'b0, 11'd390, 2'd3, 11'd344, 1'b0, 6'd46, 1'b1};
    vt[8]  = '{11, 1'b1, 1'b0, 1'b0, 11'd325, 2'd3, 11'd278, 1'b0, 6'd47, 1'b0};
    vt[9]  = '{12, 1'b1, 1'b0, 1'b0, 11'd343, 2'd3, 11'd344, 1'b0, 6'd63, 1'b0};
    vt[10] = '{1,  1'b1, 1'b0, 1'b0, 11'd400, 2'd1, 11'd356, 1'b0, 6'd44, 1'b1};
    vt[11] = '{1,  1'b0, 1'b0, 1'b0, 11'd403, 2'd3, 11'd356, 1'b0, 6'd47, 1'b0};

    rst_n            = 1'b0;
    u_if.frame_tick  = 1'b0;
    u_if.vc          = 11'd0;
    u_if.game_run    = 1'b0;
    u_if.btn_jump    = 1'b0;
    u_if.btn_duck    = 1'b0;
    u_if.collision   = 1'b0;

    #12;
    chk_pose("reset", 3, 356, 0);
    chk("reset.idx", int'(u_if.row_idx), 0);
    chk("reset.hit", int'(u_if.row_hit), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      u_if.game_run = vt[i].gr;
      u_if.btn_jump = vt[i].jmp;
      u_if.btn_duck = vt[i].dck;
      tick_n(vt[i].ticks);
      chk_pose($sformatf("vec%0d", i), int'(vt[i].sel), int'(vt[i].top), int'(vt[i].dead));
      u_if.vc = vt[i].vc;
      @(negedge clk);
      chk($sformatf("vec%0d.idx", i), int'(u_if.row_idx), int'(vt[i].idx));
      chk($sformatf("vec%0d.hit", i), int'(u_if.row_hit), int'(vt[i].hit));
    end

    // Collision between ticks while airborne: latched, then DEAD on the next tick.
    u_if.game_run = 1'b1;
    tick_n(1);
    chk_pose("d_run", 0, 356, 0);
    u_if.btn_jump = 1'b1;
    tick_n(1);
    u_if.btn_jump = 1'b0;
    tick_n(3);
    chk_pose("d_air", 3, 323, 0);
    @(negedge clk);
    u_if.collision = 1'b1;
    @(negedge clk);
    u_if.collision = 1'b0;
    @(negedge clk);
    chk_pose("d_pretick", 3, 323, 0);
    tick_n(1);
    chk_pose("d_dead", 3, 323, 1);
    u_if.btn_jump = 1'b1;
    tick_n(2);
    chk_pose("d_jumpign", 3, 323, 1);
    u_if.btn_jump = 1'b0;
    u_if.game_run = 1'b0;
    tick_n(1);
    chk_pose("d_idle", 3, 356, 0);

    // Descent from the apex with duck held.
`ifdef DINO_FAST_FALL_EN
    exp_land = 8;
`else
    exp_land = 13;
`endif
    u_if.game_run = 1'b1;
    tick_n(1);
    chk_pose("f_run", 0, 356, 0);
    u_if.btn_jump = 1'b1;
    tick_n(1);
    u_if.btn_jump = 1'b0;
    tick_n(12);
    chk_pose("f_apex", 3, 278, 0);
    u_if.btn_duck = 1'b1;
    n_land = 0;
    landed = 1'b0;
    for (int k = 0; k < 40 && !landed; k++) begin
      tick_n(1);
      n_land++;
      if (u_if.sprite_sel != 2'd3) landed = 1'b1;
    end
    chk("f_landed", int'(landed), 1);
    chk("f_land_ticks", n_land, exp_land);
    chk("f_land_top", int'(u_if.dino_top), 356);
    u_if.btn_duck = 1'b0;
    tick_n(1);

    // Asynchronous reset mid-jump at h=50.
    u_if.btn_jump = 1'b1;
    tick_n(1);
    u_if.btn_jump = 1'b0;
    tick_n(5);
    chk_pose("r_air", 3, 306, 0);
    u_if.vc = 11'd330;
    @(negedge clk);
    chk("r_air.idx", int'(u_if.row_idx), 24);
    chk("r_air.hit", int'(u_if.row_hit), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_pose("r_async", 3, 356, 0);
    chk("r_async.idx", int'(u_if.row_idx), 0);
    chk("r_async.hit", int'(u_if.row_hit), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
